// File: rtl/mem_stage_if.sv
// ============================================================================
// mem_stage_if : EX/MEM bundle in, MEM/WB bundle out for the memory stage.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_stage_if;
  logic        valid_in;
  logic [31:0] aluResult;
  logic [31:0] storeData;
  logic        memRead;
  logic        memWrite;
  logic [1:0]  memSize;
  logic        memUnsigned;
  logic        regWrite;
  logic [4:0]  rd;
  logic        memToReg;
  logic        stall;
  logic        flush;

  logic [31:0] memoriaSaida;
  logic [31:0] aluSaida;
  logic        controle;
  logic [4:0]  wbRd;
  logic        wbRegWrite;
  logic        wbValid;
  logic        misaligned;

  modport master (
    output valid_in, aluResult, storeData, memRead, memWrite, memSize,
           memUnsigned, regWrite, rd, memToReg, stall, flush,
    input  memoriaSaida, aluSaida, controle, wbRd, wbRegWrite, wbValid,
           misaligned
  );

  modport slave (
    input  valid_in, aluResult, storeData, memRead, memWrite, memSize,
           memUnsigned, regWrite, rd, memToReg, stall, flush,
    output memoriaSaida, aluSaida, controle, wbRd, wbRegWrite, wbValid,
           misaligned
  );
endinterface

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// mem_stage : pipeline memory stage with internal byte-lane data memory and
//             MEM/WB register. Optional macro: MEM_MISALIGN_TRAP_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 8
) (
  input  wire logic  Clock,
  input  wire logic  Reset,
  mem_stage_if.slave bus
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  logic [31:0] mem [DEPTH_WORDS];

  logic [ADDR_W-1:0] idx;
  logic [1:0]        lane;
  logic [1:0]        eff_lane;
  logic              is_byte;
  logic              is_half;
  logic              mis;
  logic              live;
  logic              we;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic [31:0]       rd_word;
  logic [31:0]       shifted;
  logic [31:0]       load_val;
  logic              unused_addr_hi;

  logic [31:0] memoria_d, memoria_q;
  logic [31:0] alu_d,     alu_q;
  logic        ctl_d,     ctl_q;
  logic [4:0]  wbrd_d,    wbrd_q;
  logic        regw_d,    regw_q;
  logic        valid_d,   valid_q;
  logic        mis_d,     mis_q;

  assign unused_addr_hi = ^bus.aluResult[31:ADDR_W+2];

  always_comb begin
    idx     = bus.aluResult[ADDR_W+1:2];
    lane    = bus.aluResult[1:0];
    is_byte = (bus.memSize == SZ_BYTE);
    is_half = (bus.memSize == SZ_HALF);
`ifdef MEM_MISALIGN_TRAP_EN
    mis      = (bus.memRead | bus.memWrite) &
               ((is_half & lane[0]) | (~is_byte & ~is_half & (lane != 2'b00)));
    eff_lane = lane;
`else
    // Without trapping, low address bits are forced to natural alignment.
    mis      = 1'b0;
    eff_lane = is_byte ? lane : (is_half ? {lane[1], 1'b0} : 2'b00);
`endif
    live = bus.valid_in & ~bus.flush;
    we   = bus.memWrite & live & ~bus.stall & ~mis & Reset;

    be    = 4'b1111;
    wdata = bus.storeData;
    if (is_byte) begin
      be    = 4'b0001 << eff_lane;
      wdata = {4{bus.storeData[7:0]}};
    end else if (is_half) begin
      be    = eff_lane[1] ? 4'b1100 : 4'b0011;
      wdata = {2{bus.storeData[15:0]}};
    end

    rd_word = mem[idx];
    shifted = rd_word >> {eff_lane, 3'b000};
    if (is_byte)
      load_val = {{24{shifted[7] & ~bus.memUnsigned}}, shifted[7:0]};
    else if (is_half)
      load_val = {{16{shifted[15] & ~bus.memUnsigned}}, shifted[15:0]};
    else
      load_val = shifted;
  end

  // Priority: reset, then kill (flush or invalid slot), then stall hold.
  always_comb begin
    memoria_d = memoria_q;
    alu_d     = alu_q;
    ctl_d     = ctl_q;
    wbrd_d    = wbrd_q;
    regw_d    = regw_q;
    valid_d   = valid_q;
    mis_d     = mis_q;
    if (!Reset || !live) begin
      memoria_d = 32'd0;
      alu_d     = 32'd0;
      ctl_d     = 1'b0;
      wbrd_d    = 5'd0;
      regw_d    = 1'b0;
      valid_d   = 1'b0;
      mis_d     = 1'b0;
    end else if (!bus.stall) begin
      memoria_d = (bus.memRead && !mis) ? load_val : 32'd0;
      alu_d     = bus.aluResult;
      ctl_d     = ~bus.memToReg;
      wbrd_d    = bus.rd;
      regw_d    = bus.regWrite & ~mis;
      valid_d   = 1'b1;
      mis_d     = mis;
    end
  end

  always_ff @(posedge Clock) begin
    memoria_q <= memoria_d;
    alu_q     <= alu_d;
    ctl_q     <= ctl_d;
    wbrd_q    <= wbrd_d;
    regw_q    <= regw_d;
    valid_q   <= valid_d;
    mis_q     <= mis_d;
  end

  always_ff @(posedge Clock) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i])
        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign bus.memoriaSaida = memoria_q;
  assign bus.aluSaida     = alu_q;
  assign bus.controle     = ctl_q;
  assign bus.wbRd         = wbrd_q;
  assign bus.wbRegWrite   = regw_q;
  assign bus.wbValid      = valid_q;
  assign bus.misaligned   = mis_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// tb_mem_stage : directed vector table plus hand sequences for mem_stage.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  mem_stage_if bus ();

  mem_stage #(.DEPTH_WORDS(256), .ADDR_W(8)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [31:0] alu;
    logic [31:0] sd;
    logic        rdn;
    logic        wrn;
    logic [1:0]  size;
    logic        uns;
    logic        regw;
    logic [4:0]  rd;
    logic        m2r;
    logic [31:0] e_mem;
    logic        e_ctl;
    logic        e_regw;
    logic        e_mis;
  } vec_t;

  localparam logic [1:0] B = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] W = 2'b10;

  vec_t vecs[17];

  function automatic vec_t mk(input logic [31:0] alu, input logic [31:0] sd,
                              input logic rdn, input logic wrn, input logic [1:0] size,
                              input logic uns, input logic regw, input logic [4:0] rd,
                              input logic m2r, input logic [31:0] e_mem,
                              input logic e_ctl, input logic e_regw, input logic e_mis);
    vec_t v;
    v.alu = alu; v.sd = sd; v.rdn = rdn; v.wrn = wrn; v.size = size;
    v.uns = uns; v.regw = regw; v.rd = rd; v.m2r = m2r; v.e_mem = e_mem;
    v.e_ctl = e_ctl; v.e_regw = e_regw; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [31:0] alu, input logic [31:0] sd,
                       input logic rdn, input logic wrn, input logic [1:0] size,
                       input logic uns, input logic regw, input logic [4:0] rd,
                       input logic m2r, input logic stl, input logic fl);
    bus.valid_in    = vld;
    bus.aluResult   = alu;
    bus.storeData   = sd;
    bus.memRead     = rdn;
    bus.memWrite    = wrn;
    bus.memSize     = size;
    bus.memUnsigned = uns;
    bus.regWrite    = regw;
    bus.rd          = rd;
    bus.memToReg    = m2r;
    bus.stall       = stl;
    bus.flush       = fl;
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic expect_all(input string tag, input logic [31:0] e_mem,
                            input logic [31:0] e_alu, input logic e_ctl,
                            input logic [4:0] e_rd, input logic e_regw,
                            input logic e_valid, input logic e_mis);
    chk({tag, ".memoriaSaida"}, bus.memoriaSaida, e_mem);
    chk({tag, ".aluSaida"},     bus.aluSaida,     e_alu);
    chk({tag, ".controle"},     {31'd0, bus.controle},   {31'd0, e_ctl});
    chk({tag, ".wbRd"},         {27'd0, bus.wbRd},       {27'd0, e_rd});
    chk({tag, ".wbRegWrite"},   {31'd0, bus.wbRegWrite}, {31'd0, e_regw});
    chk({tag, ".wbValid"},      {31'd0, bus.wbValid},    {31'd0, e_valid});
    chk({tag, ".misaligned"},   {31'd0, bus.misaligned}, {31'd0, e_mis});
  endtask

  initial begin
    vecs[0]  = mk(32'h10,  32'hDEADBEEF, 0, 1, W, 0, 0, 0, 0, 32'h0,        1, 0, 0);
    vecs[1]  = mk(32'h10,  32'h0,        1, 0, W, 0, 1, 5, 1, 32'hDEADBEEF, 0, 1, 0);
    vecs[2]  = mk(32'h13,  32'h0,        1, 0, B, 0, 1, 6, 1, 32'hFFFFFFDE, 0, 1, 0);
    vecs[3]  = mk(32'h13,  32'h0,        1, 0, B, 1, 1, 7, 1, 32'h000000DE, 0, 1, 0);
    vecs[4]  = mk(32'h12,  32'h0,        1, 0, H, 1, 1, 8, 1, 32'h0000DEAD, 0, 1, 0);
    vecs[5]  = mk(32'h10,  32'h0,        1, 0, H, 0, 1, 9, 1, 32'hFFFFBEEF, 0, 1, 0);
    vecs[6]  = mk(32'h11,  32'hAAAAAA55, 0, 1, B, 0, 0, 0, 1, 32'h0,        0, 0, 0);
    vecs[7]  = mk(32'h10,  32'h0,        1, 0, W, 0, 1, 10, 1, 32'hDEAD55EF, 0, 1, 0);
    vecs[8]  = mk(32'h80000001, 32'h0,   0, 0, W, 0, 1, 3, 0, 32'h0,        1, 1, 0);
    vecs[9]  = mk(32'h11,  32'h0,        1, 0, B, 0, 1, 11, 1, 32'h00000055, 0, 1, 0);
    vecs[10] = mk(32'h410, 32'h0,        1, 0, W, 0, 1, 12, 1, 32'hDEAD55EF, 0, 1, 0);
    vecs[11] = mk(32'h14,  32'hA5A5A5A5, 0, 1, W, 0, 0, 0, 1, 32'h0,        0, 0, 0);
    vecs[12] = mk(32'h14,  32'h11111111, 1, 1, W, 0, 1, 13, 1, 32'hA5A5A5A5, 0, 1, 0);
    vecs[13] = mk(32'h14,  32'h0,        1, 0, W, 0, 1, 14, 1, 32'h11111111, 0, 1, 0);
    vecs[14] = mk(32'h16,  32'hFFFF8001, 0, 1, H, 0, 0, 0, 1, 32'h0,        0, 0, 0);
    vecs[15] = mk(32'h16,  32'h0,        1, 0, H, 0, 1, 15, 1, 32'hFFFF8001, 0, 1, 0);
    vecs[16] = mk(32'h14,  32'h0,        1, 0, 2'b11, 0, 1, 16, 1, 32'h80011111, 0, 1, 0);

    // Reset with a live load presented: every output must still read 0.
    Reset = 1'b0;
    drive(1, 32'h10, 32'h0, 1, 0, W, 0, 1, 5, 0, 0, 0);
    step();
    expect_all("reset0", 32'h0, 32'h0, 0, 5'd0, 0, 0, 0);
    step();
    expect_all("reset1", 32'h0, 32'h0, 0, 5'd0, 0, 0, 0);
    Reset = 1'b1;

    for (int i = 0; i < 17; i++) begin
      drive(1, vecs[i].alu, vecs[i].sd, vecs[i].rdn, vecs[i].wrn, vecs[i].size,
            vecs[i].uns, vecs[i].regw, vecs[i].rd, vecs[i].m2r, 0, 0);
      step();
      expect_all($sformatf("vec%0d", i), vecs[i].e_mem, vecs[i].alu, vecs[i].e_ctl,
                 vecs[i].rd, vecs[i].e_regw, 1'b1, vecs[i].e_mis);
    end

    // Stalled store is frozen, then killed by flush: memory keeps old value.
    drive(1, 32'h20, 32'h0BADF00D, 0, 1, W, 0, 0, 0, 0, 0, 0);
    step();
    expect_all("sw20a", 32'h0, 32'h20, 1, 5'd0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h20, 32'h12345678, 0, 1, W, 0, 0, 9, 1, 1, 0);
      step();
      expect_all($sformatf("stallA%0d", k), 32'h0, 32'h20, 1, 5'd0, 0, 1, 0);
    end
    drive(1, 32'h20, 32'h12345678, 0, 1, W, 0, 0, 9, 1, 1, 1);
    step();
    expect_all("flush_stall", 32'h0, 32'h0, 0, 5'd0, 0, 0, 0);
    drive(1, 32'h20, 32'h0, 1, 0, W, 0, 1, 7, 1, 0, 0);
    step();
    expect_all("lw20a", 32'h0BADF00D, 32'h20, 0, 5'd7, 1, 1, 0);

    // Store held under stall for 3 cycles commits on release.
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h20, 32'h12345678, 0, 1, W, 0, 0, 0, 0, 1, 0);
      step();
      expect_all($sformatf("stallB%0d", k), 32'h0BADF00D, 32'h20, 0, 5'd7, 1, 1, 0);
    end
    drive(1, 32'h20, 32'h12345678, 0, 1, W, 0, 0, 0, 0, 0, 0);
    step();
    expect_all("sw20b", 32'h0, 32'h20, 1, 5'd0, 0, 1, 0);
    drive(1, 32'h20, 32'h0, 1, 0, W, 0, 1, 7, 1, 0, 0);
    step();
    expect_all("lw20b", 32'h12345678, 32'h20, 0, 5'd7, 1, 1, 0);

    // Flushed store to 0x24 leaves earlier contents.
    drive(1, 32'h24, 32'hCAFEBABE, 0, 1, W, 0, 0, 0, 1, 0, 0);
    step();
    drive(1, 32'h24, 32'h0, 0, 1, W, 0, 1, 2, 1, 0, 1);
    step();
    expect_all("flush24", 32'h0, 32'h0, 0, 5'd0, 0, 0, 0);
    drive(1, 32'h24, 32'h0, 1, 0, W, 0, 1, 2, 1, 0, 0);
    step();
    expect_all("lw24", 32'hCAFEBABE, 32'h24, 0, 5'd2, 1, 1, 0);
    drive(0, 32'h24, 32'h0, 1, 0, W, 0, 1, 2, 1, 0, 0);
    step();
    expect_all("invalid", 32'h0, 32'h0, 0, 5'd0, 0, 0, 0);

    // Reset during a stall, then reset with the store unstalled: store dropped.
    drive(1, 32'h28, 32'h01010101, 0, 1, W, 0, 0, 0, 1, 0, 0);
    step();
    drive(1, 32'h28, 32'hFFFFFFFF, 0, 1, W, 0, 1, 4, 1, 1, 0);
    step();
    Reset = 1'b0;
    step();
    expect_all("rst_stall", 32'h0, 32'h0, 0, 5'd0, 0, 0, 0);
    drive(1, 32'h28, 32'hFFFFFFFF, 0, 1, W, 0, 1, 4, 1, 0, 0);
    step();
    expect_all("rst_nostall", 32'h0, 32'h0, 0, 5'd0, 0, 0, 0);
    Reset = 1'b1;
    drive(1, 32'h28, 32'h0, 1, 0, W, 0, 1, 4, 1, 0, 0);
    step();
    expect_all("lw28", 32'h01010101, 32'h28, 0, 5'd4, 1, 1, 0);

    // Misaligned word store and half load.
    drive(1, 32'h22, 32'hA1B2C3D4, 0, 1, W, 0, 1, 4, 0, 0, 0);
    step();
`ifdef MEM_MISALIGN_TRAP_EN
    expect_all("sw22", 32'h0, 32'h22, 1, 5'd4, 0, 1, 1);
`else
    expect_all("sw22", 32'h0, 32'h22, 1, 5'd4, 1, 1, 0);
`endif
    drive(1, 32'h20, 32'h0, 1, 0, W, 0, 1, 6, 1, 0, 0);
    step();
`ifdef MEM_MISALIGN_TRAP_EN
    expect_all("lw20c", 32'h12345678, 32'h20, 0, 5'd6, 1, 1, 0);
`else
    expect_all("lw20c", 32'hA1B2C3D4, 32'h20, 0, 5'd6, 1, 1, 0);
`endif
    drive(1, 32'h21, 32'h0, 1, 0, H, 0, 1, 6, 1, 0, 0);
    step();
`ifdef MEM_MISALIGN_TRAP_EN
    expect_all("lh21", 32'h0, 32'h21, 0, 5'd6, 0, 1, 1);
`else
    expect_all("lh21", 32'hFFFFC3D4, 32'h21, 0, 5'd6, 1, 1, 0);
`endif
    drive(1, 32'h21, 32'h0, 1, 0, H, 0, 1, 6, 1, 0, 1);
    step();
    expect_all("flush_mis", 32'h0, 32'h0, 0, 5'd0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, feeding the write-back mux directly. Takes the EX/MEM bundle, performs byte/half/word loads and stores against an internal synchronous data memory, and registers the MEM/WB bundle. Outputs `memoriaSaida`, `aluSaida` and `controle` connect straight to the WB `Mux2_1`.

## Interface
- `DEPTH_WORDS`, 256: data memory depth in 32-bit words; power of two.
- `ADDR_W`, 8: word-address bits, equal to log2(`DEPTH_WORDS`).

- `Clock`  in  1  rising-edge clock.
- `Reset`  in  1  synchronous, active-low reset.
- `valid_in`  in  1  EX/MEM bundle valid.
- `aluResult`  in  32  ALU result; effective address for loads and stores.
- `storeData`  in  32  store source (rt).
- `memRead`  in  1  load.
- `memWrite`  in  1  store.
- `memSize`  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- `memUnsigned`  in  1  zero-extend loads (lbu/lhu) when 1; sign-extend when 0.
- `regWrite`  in  1  instruction writes the register file.
- `rd`  in  5  destination register.
- `memToReg`  in  1  1 means WB selects the memory result.
- `stall`  in  1  hold MEM/WB register and block memory writes.
- `flush`  in  1  kill the instruction currently in EX/MEM.
- `memoriaSaida`  out  32  registered load result.
- `aluSaida`  out  32  registered `aluResult`.
- `controle`  out  1  WB mux select: 0 selects `memoriaSaida`, 1 selects `aluSaida` (registered `~memToReg`).
- `wbRd`  out  5  registered `rd`.
- `wbRegWrite`  out  1  registered write enable, qualified as described under Operation.
- `wbValid`  out  1  MEM/WB valid.
- `misaligned`  out  1  registered misaligned-access flag.

## Operation
- Word index is `aluResult[ADDR_W+1:2]`. Upper address bits are ignored, so addresses wrap modulo `4*DEPTH_WORDS` bytes. Byte lane is `aluResult[1:0]`, little-endian: lane 0 = bits 7:0.
- Memory is read asynchronously and written on the clock edge.
- Memory contents are not reset.
- Store byte: writes `storeData[7:0]` to the addressed lane.
- Store half: writes `storeData[15:0]` to lanes {1,0} or {3,2}.
- Store word: writes all four lanes.
- Load: selects the lane(s), then sign- or zero-extends per `memUnsigned`.
- When `memRead=0`, `memoriaSaida` loads 0.
- Misaligned: half with `aluResult[0]=1`, or word with `aluResult[1:0]≠0`, on an access with `memRead` or `memWrite` set. On a misaligned access:
  - no memory write;
  - `memoriaSaida`=0;
  - `wbRegWrite`=0;
  - `misaligned`=1 for that MEM/WB slot.
- Effective write enable = `memWrite & valid_in & ~stall & ~flush & ~misaligned & Reset`.
- `wbRegWrite` = `regWrite & valid_in & ~flush & ~misaligned`.
- `memRead` and `memWrite` together: the store happens and the load returns the old data.

## Timing
- Latency: 1 cycle, EX/MEM inputs to MEM/WB outputs.
- A store is visible to a load issued on the following cycle.
- Reset (`Reset`=0 at an edge): all outputs become 0, including `wbValid`, `wbRegWrite` and `misaligned`, and `controle` becomes 0. No memory write that cycle.
- Priority: Reset > flush > stall > normal.
- Flush: next-cycle `wbValid`=0, `wbRegWrite`=0, `misaligned`=0; store suppressed. Data fields are don't-care but must load 0.
- Stall: all MEM/WB outputs hold their values, no memory write. Upstream holds EX/MEM, so a held store commits exactly once, on the first edge with `stall`=0.
- `valid_in`=0: behaves as a flush for that slot.
- Reset asserted mid-stall: outputs cleared; the pending store is dropped.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined: misalignment detection and handling exactly as described under Operation.
- Not defined:
  - low address bits are forced to natural alignment (`aluResult[0]` ignored for half; `aluResult[1:0]` ignored for word);
  - the access proceeds normally;
  - `misaligned` is tied to 0.

## Test plan
- Reset: `Reset`=0 for 2 cycles -> all outputs 0. Release, then issue a word store with address 0x10, data 0xDEADBEEF, followed by a signed word load from 0x10 -> `memoriaSaida`=0xDEADBEEF, `controle`=0, `wbRegWrite`=1.
- Byte/half extension, with word 0x10 = 0xDEADBEEF:
  - signed byte load at 0x13 -> 0xFFFFFFDE;
  - unsigned byte load at 0x13 -> 0x000000DE;
  - unsigned half load at 0x12 -> 0x0000DEAD;
  - signed half load at 0x10 -> 0xFFFFBEEF.
- Partial store: byte store of 0x55 at 0x11, then word load at 0x10 -> 0xDEAD55EF.
- ALU path: `memToReg`=0, `aluResult`=0x80000001 -> `controle`=1, `aluSaida`=0x80000001, `memoriaSaida`=0.
- Stall and flush:
  - store 0x12345678 at 0x20 with `stall`=1 for 3 cycles -> outputs frozen;
  - load on the cycle after the stall releases -> 0x12345678, so the store occurred once;
  - store to 0x24 with `flush`=1 -> a later load from 0x24 returns the old contents, and `wbValid`=0 in the flushed slot.
- Misaligned (macro defined): word store at 0x22 -> no write, `misaligned`=1, `wbRegWrite`=0. Without the macro, the same store writes word 0x20.
